cordic_sincos_unroll_param: RTL and testbench

- Parametrised iterative CORDIC sine/cosine unit, packaged as a multi-cycle Nios custom instruction.
- Generalises the fixed 21-bit, 2-unroll cosine core. Adds configurable word length, unroll factor and iteration count.
- Adds a runtime sine/cosine select, a registered done pulse, a busy flag and restart-on-start.
- Float in, float out; input range |angle| < 1.0 rad.

---
 rtl/cordic_sincos_unroll_param.sv | 178 +++++++++++++++++
 tb/tb_cordic_sincos_unroll_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_unroll_param.sv
// Iterative CORDIC sine/cosine custom instruction: float angle in, float result out.
// UNROLLS micro-rotations are chained combinationally each RUN cycle.
module cordic_sincos_unroll_param #(
    parameter int WL         = 21,
    parameter int ITERATIONS = 16,
    parameter int UNROLLS    = 2
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic        n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam int N  = ITERATIONS / UNROLLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(ITERATIONS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [WL-1:0] K_CONST = WL'($rtoi(0.6072529350 * (2.0 ** (WL - 1)) + 0.5));
    localparam logic signed [WL-1:0] MAX_POS = {1'b0, {(WL-1){1'b1}}};
    localparam logic signed [WL-1:0] MIN_NEG = {1'b1, {(WL-1){1'b0}}};

    if ((ITERATIONS % UNROLLS) != 0) begin : g_bad_unroll
        $error("UNROLLS must divide ITERATIONS");
    end

    logic signed [WL-1:0] atan_tab [ITERATIONS];

    for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_atan
        localparam logic signed [WL-1:0] ATAN_I =
            WL'($rtoi($atan(1.0 / (2.0 ** gi)) * (2.0 ** (WL - 1)) + 0.5));
        assign atan_tab[gi] = ATAN_I;
    end

    logic [1:0]           state_reg;
    logic [CW-1:0]        cnt_reg;
    logic signed [WL-1:0] x_reg, y_reg, z_reg;
    logic                 mode_reg, sgn_reg, done_reg;
    logic [31:0]          result_reg;

    // Clamp a one-bit-wider sum back into the Q1 range instead of wrapping.
    function automatic logic signed [WL-1:0] sat(input logic signed [WL:0] v);
        if (v[WL] != v[WL-1])
            sat = v[WL] ? MIN_NEG : MAX_POS;
        else
            sat = v[WL-1:0];
    endfunction

    // |dataa| to Q1.(WL-1): the 27-bit extended mantissa is scaled by a right shift.
    logic [7:0]           in_exp;
    logic [26:0]          in_mant_ext;
    int                   rsh;
    logic signed [WL-1:0] z_in;

    always_comb begin
        in_exp      = dataa[30:23];
        in_mant_ext = {1'b1, dataa[22:0], 3'b000};
        rsh         = 154 - WL - int'(in_exp);
        z_in        = '0;
        if (in_exp >= 8'd127)
            z_in = MAX_POS;
        else if (in_exp == 8'd0)
            z_in = '0;
        else if (rsh < 27)
            z_in = WL'(in_mant_ext >> rsh);
    end

    logic [IW-1:0]        idx;
    logic signed [WL-1:0] x_c, y_c, z_c, xsh, ysh;
    logic signed [WL:0]   xw, yw;
    logic signed [WL-1:0] x_next, y_next, z_next;

    always_comb begin
        x_c = x_reg;
        y_c = y_reg;
        z_c = z_reg;
        idx = '0;
        xsh = '0;
        ysh = '0;
        xw  = '0;
        yw  = '0;
        for (int j = 0; j < UNROLLS; j++) begin
            idx = IW'(int'(cnt_reg) * UNROLLS + j);
            xsh = x_c >>> idx;
            ysh = y_c >>> idx;
            if (z_c[WL-1]) begin
                xw  = {x_c[WL-1], x_c} + {ysh[WL-1], ysh};
                yw  = {y_c[WL-1], y_c} - {xsh[WL-1], xsh};
                z_c = z_c + atan_tab[idx];
            end else begin
                xw  = {x_c[WL-1], x_c} - {ysh[WL-1], ysh};
                yw  = {y_c[WL-1], y_c} + {xsh[WL-1], xsh};
                z_c = z_c - atan_tab[idx];
            end
            x_c = sat(xw);
            y_c = sat(yw);
        end
        x_next = x_c;
        y_next = y_c;
        z_next = z_c;
    end

    // Sign-magnitude to single precision; the leading one sets the exponent.
    logic signed [WL-1:0] out_v;
    logic [WL-1:0]        out_mag;
    logic                 out_neg;
    int                   lead;
    logic [31:0]          out_float;

    always_comb begin
        out_v   = mode_reg ? y_reg : x_reg;
        out_neg = out_v[WL-1];
        out_mag = out_neg ? WL'(-out_v) : out_v;
        lead    = 0;
        for (int b = 0; b < WL; b++)
            if (out_mag[b]) lead = b;
        out_float = {out_neg ^ (mode_reg & sgn_reg),
                     8'(127 + lead - (WL - 1)),
                     23'(({out_mag, 23'b0} << (WL - 1 - lead)) >> (WL - 1))};
        if (out_mag == '0)
            out_float = '0;
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            x_reg      <= K_CONST;
            y_reg      <= '0;
            z_reg      <= '0;
            mode_reg   <= 1'b0;
            sgn_reg    <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (clk_en) begin
            done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    x_reg   <= x_next;
                    y_reg   <= y_next;
                    z_reg   <= z_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    result_reg <= out_float;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: ;
            endcase
            // A start in any state reloads; it overrides the RUN/DONE transitions above.
            if (start) begin
                x_reg     <= K_CONST;
                y_reg     <= '0;
                z_reg     <= z_in;
                mode_reg  <= n;
                sgn_reg   <= dataa[31];
                cnt_reg   <= '0;
                state_reg <= RUN;
            end
        end
    end

    assign result = result_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_cordic_sincos_unroll_param.sv
// Scoreboarded bench for three CORDIC configurations; results checked against $sin/$cos.
module tb_cordic_sincos_unroll_param;

    localparam int NI = 3;
    localparam int WL_P [NI] = '{21, 24, 16};
    localparam int IT_P [NI] = '{16, 20, 12};
    localparam int UN_P [NI] = '{2, 4, 1};

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        start_s  [NI];
    logic        n_s      [NI];
    logic [31:0] dataa_s  [NI];
    logic [31:0] result_s [NI];
    logic        done_s   [NI];
    logic        busy_s   [NI];

    always #5 clock = ~clock;

    cordic_sincos_unroll_param u_def (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start_s[0]), .n(n_s[0]),
        .dataa(dataa_s[0]), .result(result_s[0]), .done(done_s[0]), .busy(busy_s[0]));

    cordic_sincos_unroll_param #(.WL(24), .ITERATIONS(20), .UNROLLS(4)) u_w24 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start_s[1]), .n(n_s[1]),
        .dataa(dataa_s[1]), .result(result_s[1]), .done(done_s[1]), .busy(busy_s[1]));

    cordic_sincos_unroll_param #(.WL(16), .ITERATIONS(12), .UNROLLS(1)) u_w16 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start_s[2]), .n(n_s[2]),
        .dataa(dataa_s[2]), .result(result_s[2]), .done(done_s[2]), .busy(busy_s[2]));

    typedef struct {
        int    inst;
        real   expv;
        real   tol;
        string tag;
    } sb_t;

    sb_t sb [$];
    int  errors = 0;
    int  checks = 0;
    int  done_cnt [NI] = '{0, 0, 0};

    function automatic real f2r(input logic [31:0] b);
        int  e;
        real m;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    // Angle the DUT actually rotates through, including input saturation.
    function automatic real angle_of(input int inst, input logic [31:0] b);
        real a;
        if (b[30:23] >= 8'd127) begin
            a = 1.0 - 2.0 ** (-(WL_P[inst] - 1));
            return b[31] ? -a : a;
        end
        return f2r(b);
    endfunction

    task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real expv, input real tol);
        real d;
        d = obs - expv;
        if (d < 0.0) d = -d;
        checks++;
        assert (d <= tol) else begin
            errors++;
            $error("FAIL %s: observed=%f expected=%f tol=%g", tag, obs, expv, tol);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic launch(input int inst, input bit mode, input logic [31:0] bits,
                          input bit keep, input string tag);
        sb_t e;
        real a;
        start_s[inst] = 1'b1;
        n_s[inst]     = mode;
        dataa_s[inst] = bits;
        if (keep) begin
            a      = angle_of(inst, bits);
            e.inst = inst;
            e.expv = mode ? $sin(a) : $cos(a);
            // Residual angle of the last micro-rotation plus datapath quantisation.
            e.tol  = 2.0 ** (-(WL_P[inst] - 5)) + 2.0 ** (-(IT_P[inst] - 3));
            e.tag  = tag;
            sb.push_back(e);
        end
        @(negedge clock);
        start_s[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget, output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        while (!done_s[inst] && lat < budget) begin
            if (!busy_s[inst]) busy_low++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_op(input int inst, input bit mode, input logic [31:0] bits, input string tag);
        int lat, bl;
        launch(inst, mode, bits, 1'b1, tag);
        wait_done(inst, 40, lat, bl);
        chk_int({tag, "_latency"}, lat, IT_P[inst] / UN_P[inst] + 1);
        chk_int({tag, "_busy_run"}, bl, 0);
        chk_bits({tag, "_busy_done"}, {31'b0, busy_s[inst]}, 32'h0);
    endtask

    // Scoreboard consumer: one pop per rising edge of done.
    initial begin
        logic prev [NI];
        sb_t  e;
        bit   ok;
        for (int i = 0; i < NI; i++) prev[i] = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) begin
                if (done_s[i] === 1'b1 && !prev[i]) begin
                    done_cnt[i]++;
                    ok = (sb.size() > 0) && (sb[0].inst == i);
                    checks++;
                    assert (ok) else begin
                        errors++;
                        $error("FAIL unexpected_done_inst%0d: observed=done expected=no pending op", i);
                    end
                    if (ok) begin
                        e = sb.pop_front();
                        chk_real(e.tag, f2r(result_s[i]), e.expv, e.tol);
                    end
                end
                prev[i] = done_s[i];
            end
        end
    end

    initial begin
        int          lat, bl, d0, hold_bad;
        logic [31:0] r;
        logic [31:0] bits;
        bit          mode;

        aclr   = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            n_s[i]     = 1'b0;
            dataa_s[i] = 32'h0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk_bits($sformatf("reset_result_%0d", i), result_s[i], 32'h0);
            chk_bits($sformatf("reset_done_%0d", i), {31'b0, done_s[i]}, 32'h0);
            chk_bits($sformatf("reset_busy_%0d", i), {31'b0, busy_s[i]}, 32'h0);
        end
        aclr = 1'b0;
        @(negedge clock);

        launch(0, 1'b0, 32'h3F000000, 1'b1, "cos_0p5");
        wait_done(0, 40, lat, bl);
        chk_int("cos_0p5_latency", lat, 9);
        chk_int("cos_0p5_busy_run", bl, 0);
        chk_bits("cos_0p5_busy_done", {31'b0, busy_s[0]}, 32'h0);
        @(negedge clock);
        chk_bits("done_one_cycle", {31'b0, done_s[0]}, 32'h0);

        run_op(0, 1'b1, 32'hBF000000, "sin_m0p5");
        run_op(0, 1'b0, 32'hBF000000, "cos_m0p5");
        run_op(0, 1'b0, 32'h00000000, "cos_zero");
        run_op(0, 1'b1, 32'h40000000, "sin_sat");

        // Abort: restart on the 4th RUN edge; only the second op completes.
        d0 = done_cnt[0];
        launch(0, 1'b0, 32'h3F000000, 1'b0, "aborted");
        repeat (3) @(negedge clock);
        launch(0, 1'b0, 32'h3E800000, 1'b1, "cos_0p25_restart");
        wait_done(0, 40, lat, bl);
        chk_int("restart_latency", lat, 9);
        repeat (12) @(negedge clock);
        chk_int("restart_single_done", done_cnt[0] - d0, 1);

        // Start coinciding with the DONE edge.
        launch(0, 1'b0, 32'h3F000000, 1'b1, "b2b_first");
        repeat (8) @(negedge clock);
        launch(0, 1'b1, 32'h3E800000, 1'b1, "b2b_second");
        chk_bits("b2b_done", {31'b0, done_s[0]}, 32'h1);
        chk_bits("b2b_busy", {31'b0, busy_s[0]}, 32'h1);
        @(negedge clock);
        wait_done(0, 40, lat, bl);
        chk_int("b2b_second_latency", lat + 1, 9);
        chk_int("b2b_busy_run", bl, 0);

        // Stall three cycles mid-RUN, then three more while done is high.
        launch(0, 1'b0, 32'h3E800000, 1'b1, "cos_0p25_stall");
        repeat (2) @(negedge clock);
        clk_en = 1'b0;
        repeat (3) @(negedge clock);
        clk_en = 1'b1;
        wait_done(0, 40, lat, bl);
        chk_int("stall_latency", lat + 5, 12);
        r        = result_s[0];
        hold_bad = 0;
        clk_en   = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done_s[0] !== 1'b1 || result_s[0] !== r) hold_bad++;
        end
        chk_int("stall_hold_done_result", hold_bad, 0);
        clk_en = 1'b1;
        @(negedge clock);
        chk_bits("stall_done_clears", {31'b0, done_s[0]}, 32'h0);

        // Reset mid-RUN, with start asserted alongside it.
        d0 = done_cnt[0];
        launch(0, 1'b0, 32'h3F000000, 1'b0, "reset_victim");
        repeat (2) @(negedge clock);
        aclr       = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clock);
        aclr       = 1'b0;
        start_s[0] = 1'b0;
        chk_bits("aclr_result", result_s[0], 32'h0);
        chk_bits("aclr_busy", {31'b0, busy_s[0]}, 32'h0);
        chk_bits("aclr_done", {31'b0, done_s[0]}, 32'h0);
        repeat (12) @(negedge clock);
        chk_int("aclr_no_done", done_cnt[0] - d0, 0);
        chk_bits("aclr_start_ignored", {31'b0, busy_s[0]}, 32'h0);

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < ((i == 0) ? 200 : 1000); k++) begin
                bits = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 126)), 23'($urandom)};
                mode = 1'($urandom_range(0, 1));
                run_op(i, mode, bits, $sformatf("rnd%0d_%0d", i, k));
            end
        end

        repeat (5) @(negedge clock);
        chk_int("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
